// File: rtl/riscv_pkg.sv
// Shared front-end definitions: address/data widths, fetch FSM encoding and
// the prefetch queue entry layout.
package riscv_pkg;

    localparam int ADDR_W = 13;
    localparam int XLEN   = 32;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0]   data;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_sync_fifo.sv
// Single-clock FIFO with synchronous flush; the head word is visible on rdata
// with no read latency.
module sync_fifo #(
    parameter  int WIDTH = 45,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every use of it.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/ifetch.sv
// Instruction prefetcher: streams sequential words from a 1-cycle memory into
// a small queue, with redirect flushing and in-flight response discard.
module ifetch
    import riscv_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = 13'h0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [XLEN-1:0]   mem_rd_data,
    input  logic              mem_rd_valid,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [XLEN-1:0]   inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              in_flight_q, in_flight_d;
    logic              discard_q, discard_d;
    logic              issue, push, pop;
    logic [5:0]        outstanding, next_outstanding;
    logic [CW-1:0]     count;
    logic              full, empty;
    fetch_entry_t      wr_entry, head;

    // Outstanding = queued words plus the read still in flight; a read is only
    // issued when its response is guaranteed a slot.
    always_comb begin
        outstanding      = 6'(count) + 6'(in_flight_q);
        issue            = !rst && (state_q == FETCH) && !redir_valid
                           && ((outstanding + 6'd1) <= 6'(FIFO_DEPTH));
        push             = mem_rd_valid && in_flight_q && !discard_q && !redir_valid;
        pop              = !empty && inst_ready;
        next_outstanding = 6'(count) + 6'(push) - 6'(pop) + 6'(issue);

        state_d     = state_q;
        fpc_d       = fpc_q;
        rd_addr_d   = rd_addr_q;
        in_flight_d = issue;
        discard_d   = 1'b0;

        if (redir_valid) begin
            state_d   = FETCH;
            fpc_d     = word_align(redir_pc);
            discard_d = in_flight_q;
        end else begin
            state_d = (next_outstanding >= 6'(FIFO_DEPTH)) ? HOLD : FETCH;
            if (issue) begin
                fpc_d     = word_align(fpc_q) + ADDR_W'(4);
                rd_addr_d = word_align(fpc_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            fpc_q       <= RESET_PC;
            rd_addr_q   <= '0;
            in_flight_q <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            rd_addr_q   <= rd_addr_d;
            in_flight_q <= in_flight_d;
            discard_q   <= discard_d;
        end
    end

    assign wr_entry = '{data: mem_rd_data, pc: rd_addr_q};

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redir_valid),
        .wdata (wr_entry),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign mem_rd_en  = issue;
    assign mem_addr   = issue ? word_align(fpc_q) : '0;
    assign inst_valid = !empty;
    assign inst_data  = empty ? '0 : head.data;
    assign inst_pc    = empty ? '0 : head.pc;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop && !redir_valid));

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch: a 1-cycle memory model plus a sequential-stream
// reference model of expected fetch and delivery addresses.
module tb_ifetch;

    localparam int          FIFO_DEPTH = 4;
    localparam logic [12:0] RESET_PC   = 13'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd_en;
    logic [12:0] mem_addr;
    logic [31:0] mem_rd_data;
    logic        mem_rd_valid;
    logic        redir_valid = 1'b0;
    logic [12:0] redir_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [12:0] inst_pc;

    logic [31:0] mem [2048];
    logic        mem_vld_r = 1'b0;
    logic [31:0] mem_dat_r = '0;
    logic        stray = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [12:0] exp_pc = RESET_PC;
    logic [12:0] exp_fetch = RESET_PC;
    int          issued = 0;
    int          accepted = 0;
    int          rd_count = 0;
    logic        redir_prev = 1'b0;
    logic [12:0] acc_q [$];

    ifetch #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_data    (inst_data),
        .inst_pc      (inst_pc)
    );

    initial forever #5 clk = ~clk;

    // Memory answers every read exactly one cycle later; stray injects an
    // unsolicited response.
    always @(posedge clk) begin
        mem_vld_r <= mem_rd_en;
        mem_dat_r <= mem[mem_addr[12:2]];
    end

    assign mem_rd_valid = mem_vld_r | stray;
    assign mem_rd_data  = stray ? 32'hDEAD_BEEF : mem_dat_r;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then compare the
    // outputs against the stream model and advance it.
    task automatic applyStimulus(input logic r, input logic rdy, input logic rv,
                                 input logic [12:0] rpc, input logic st);
        @(negedge clk);
        rst         = r;
        inst_ready  = rdy;
        redir_valid = rv;
        redir_pc    = rpc;
        stray       = st;
        #1;
        if (r) begin
            checkOutput("rst_rd_en", 32'(mem_rd_en), 32'd0);
            checkOutput("rst_addr", 32'(mem_addr), 32'd0);
            checkOutput("rst_valid", 32'(inst_valid), 32'd0);
            checkOutput("rst_data", inst_data, 32'd0);
            checkOutput("rst_pc", 32'(inst_pc), 32'd0);
            exp_pc     = RESET_PC;
            exp_fetch  = RESET_PC;
            issued     = 0;
            accepted   = 0;
            redir_prev = 1'b0;
        end else begin
            if (redir_prev) checkOutput("valid_after_redir", 32'(inst_valid), 32'd0);
            if (rv) checkOutput("no_issue_on_redir", 32'(mem_rd_en), 32'd0);
            if (mem_rd_en) begin
                checkOutput("fetch_addr", 32'(mem_addr), 32'(exp_fetch));
                checkOutput("fetch_room", 32'((issued - accepted) < FIFO_DEPTH), 32'd1);
                exp_fetch = exp_fetch + 13'd4;
                issued++;
                rd_count++;
            end
            if (inst_valid) begin
                checkOutput("head_pc", 32'(inst_pc), 32'(exp_pc));
                checkOutput("head_data", inst_data, mem[exp_pc[12:2]]);
                if (rdy) begin
                    acc_q.push_back(inst_pc);
                    exp_pc = exp_pc + 13'd4;
                    accepted++;
                end
            end
            if (rv) begin
                exp_pc    = {rpc[12:2], 2'b00};
                exp_fetch = {rpc[12:2], 2'b00};
                issued    = 0;
                accepted  = 0;
            end
            redir_prev = rv;
        end
    endtask

    initial begin
        bit          seen;
        int          base;
        logic [12:0] exp4 [4];

        for (int i = 0; i < 2048; i++) mem[i] = 32'(i);

        // Reset release with ready held high: words 0,1,2 from cycle 2 on.
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
            if (c == 0) begin
                checkOutput("t1_first_rd_en", 32'(mem_rd_en), 32'd1);
                checkOutput("t1_first_addr", 32'(mem_addr), 32'(RESET_PC));
            end
            if (c < 2) checkOutput("t1_valid_early", 32'(inst_valid), 32'd0);
            if (c >= 2 && c <= 4) begin
                checkOutput("t1_valid", 32'(inst_valid), 32'd1);
                checkOutput("t1_data", inst_data, 32'(c - 2));
            end
        end

        for (int i = 0; i < 2048; i++) mem[i] = $urandom;

        // Consumer stalled for 10 cycles: queue fills and fetch holds.
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        rd_count = 0;
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("t2_reads", 32'(rd_count), 32'd4);
        checkOutput("t2_hold", 32'(dut.state_q == riscv_pkg::HOLD), 32'd1);
        checkOutput("t2_head_pc", 32'(inst_pc), 32'h000);
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
            checkOutput("t2_no_gap", 32'(inst_valid), 32'd1);
        end

        // Redirect to 0x103 while the read of 0x010 is outstanding.
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
            if (c == 4) checkOutput("t3_inflight_addr", 32'(mem_addr), 32'h010);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 13'h103, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
            if (inst_valid && !seen) begin
                seen = 1'b1;
                checkOutput("t3_redir_pc", 32'(inst_pc), 32'h100);
                checkOutput("t3_redir_data", inst_data, mem[11'h040]);
            end
        end
        checkOutput("t3_redir_seen", 32'(seen), 32'd1);

        // Redirect near the top of the address space: stream wraps to zero.
        applyStimulus(1'b0, 1'b1, 1'b1, 13'h1FF8, 1'b0);
        acc_q.delete();
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("t4_count", 32'(acc_q.size() >= 4), 32'd1);
        exp4 = '{13'h1FF8, 13'h1FFC, 13'h0000, 13'h0004};
        if (acc_q.size() >= 4)
            for (int i = 0; i < 4; i++) checkOutput("t4_wrap_pc", 32'(acc_q[i]), 32'(exp4[i]));

        // Randomly throttled consumer: the model checks every presented word.
        acc_q.delete();
        repeat (1000) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
        checkOutput("t5_progress", 32'(acc_q.size() > 200), 32'd1);
        base = acc_q.size();
        repeat (20) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("t5_drain", 32'((acc_q.size() - base) >= 18), 32'd1);

        // One-cycle reset mid-stream, then an unsolicited response on release.
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        acc_q.delete();
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
        checkOutput("t6_restart_en", 32'(mem_rd_en), 32'd1);
        checkOutput("t6_restart_addr", 32'(mem_addr), 32'(RESET_PC));
        checkOutput("t6_no_stale", 32'(inst_valid), 32'd0);
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("t6_count", 32'(acc_q.size() >= 4), 32'd1);
        if (acc_q.size() >= 1) checkOutput("t6_first_pc", 32'(acc_q[0]), 32'(RESET_PC));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the prefetch queue depth in words; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter RESET_PC, default 13'h0000, meaning the byte address fetched first after reset; it is word aligned.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port mem_rd_en, output, 1 bit: memory read request.
REQ-006 SHALL have port mem_addr, output, 13 bits: memory byte address.
REQ-007 SHALL have port mem_rd_data, input, 32 bits: memory read word.
REQ-008 SHALL have port mem_rd_valid, input, 1 bit: mem_rd_data is valid; it rises exactly one cycle after mem_rd_en.
REQ-009 SHALL have port redir_valid, input, 1 bit: pipeline redirect (branch/jump) strobe.
REQ-010 SHALL have port redir_pc, input, 13 bits: redirect target; bits [1:0] are ignored.
REQ-011 SHALL have port inst_valid, output, 1 bit: the queue head is presented.
REQ-012 SHALL have port inst_ready, input, 1 bit: the consumer accepts the head.
REQ-013 SHALL have port inst_data, output, 32 bits: instruction word at the head.
REQ-014 SHALL have port inst_pc, output, 13 bits: byte address of inst_data.

Function
REQ-015 SHALL keep a fetch pointer fpc, which advances by 4 on each issued read and wraps modulo 2^13 (13'h1FFC -> 13'h0000).
REQ-016 SHALL drive mem_rd_en=1 in any cycle where state=FETCH, redir_valid=0, and occupancy + in_flight + 1 <= FIFO_DEPTH; mem_addr=fpc with bits [1:0] forced to zero.
REQ-017 SHALL set in_flight for exactly one cycle after each issue, and treat mem_rd_valid without a matching in_flight as an ignored error.
REQ-018 SHALL, on mem_rd_valid with no discard pending, push {mem_rd_data, address of that read} into the queue in the same edge.
REQ-019 SHALL present the queue head combinationally: inst_valid = not empty; inst_data and inst_pc = the head entry; zero latency from head to output.
REQ-020 SHALL pop the head on inst_valid && inst_ready; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-021 SHALL keep inst_data and inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-022 SHALL implement the state machine:
- FETCH -> HOLD when the queue plus in-flight reaches FIFO_DEPTH.
- HOLD -> FETCH when space frees.
- Any state -> FETCH on redir_valid.
REQ-023 SHALL, on redir_valid, do the following at that edge:
- Clear the queue.
- Set fpc = {redir_pc[12:2], 2'b00}.
- If a read is in flight, set discard so its response is dropped next cycle.
- Issue no read in the redirect cycle; the first read to the target follows in the next cycle.
REQ-024 SHALL drive inst_valid=0 in the cycle after redir_valid; a pop coincident with redir_valid is accepted and still consumed.
REQ-025 SHALL have the queue overflow impossible by construction; an assertion SHALL check it.
REQ-026 SHALL sustain throughput of one instruction per cycle when inst_ready is held at 1, after an initial two-cycle latency from issue to inst_valid.

Reset
REQ-027 SHALL, while rst=1, hold:
- mem_rd_en=0, mem_addr=0.
- inst_valid=0, inst_data=0, inst_pc=0.
- fpc=RESET_PC, state=FETCH.
- Queue empty, in_flight=0, discard=0.
REQ-028 SHALL issue the first read (addr=RESET_PC) in the first cycle after rst deasserts.
REQ-029 SHALL, if rst asserts mid-operation, drop any in-flight response arriving after reset deassertion.

Structure
REQ-030 SHALL place the state encoding (FETCH, HOLD), ADDR_W=13, and XLEN=32 in the shared package riscv_pkg.
REQ-031 SHALL use one sub-module, sync_fifo, with parameters WIDTH=45 and DEPTH=FIFO_DEPTH, and outputs count, full, and empty.

Verification
REQ-032 The bench SHALL cover reset release with inst_ready=1 and memory preloaded with mem[i]=i -> reads at 0,4,8,...; inst_valid first rises cycle 2; inst_data=0,1,2 on consecutive cycles.
REQ-033 The bench SHALL cover inst_ready=0 for 10 cycles, FIFO_DEPTH=4 -> exactly 4 reads issued, state=HOLD, inst_pc=0x000 stable; inst_ready=1 resumes with no gap or duplicate.
REQ-034 The bench SHALL cover redir_valid with redir_pc=0x103 while a read of 0x010 is in flight -> 0x010 response dropped; next inst_pc=0x100, inst_data=mem[0x40].
REQ-035 The bench SHALL cover a redirect to 0x1FF8 -> inst_pc sequence 0x1FF8, 0x1FFC, 0x0000, 0x0004.
REQ-036 The bench SHALL cover inst_ready toggling randomly for 1000 cycles -> inst_pc strictly +4 per accepted word, with no loss and no reordering.
REQ-037 The bench SHALL cover rst pulsed for 1 cycle mid-stream with reads in flight -> outputs at reset values; fetch restarts at RESET_PC; no stale word delivered.
